// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: datapath width, PC step and
// the default reset vector.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INCR = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_imem.sv
// Word-addressed instruction memory: one synchronous write port and one
// combinational (zero-latency) read port with no write-to-read bypass.
module fetch_imem
    import fetch_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [XLEN-1:0]   rd_data
);

    // Zero fill only matters for simulation; hardware contents start undefined.
    logic [XLEN-1:0] mem [MEM_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read sees the stored word, so a same-address write shows up only after its edge.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register with +4 incrementer feeding an instruction memory.
// Optional macro FETCH_STALL_EN adds a stall input that freezes the PC.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              MEM_WORDS = 1024,
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FETCH_STALL_EN
    input  logic             stall,
`endif
    input  logic             mem_wr,
    input  logic [XLEN-1:0]  mem_waddr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_next,
    output logic [XLEN-1:0]  instruction
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [XLEN-1:0]  pc_reg;
    logic             advance;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_waddr_bits;

`ifdef FETCH_STALL_EN
    assign advance = ~stall;
`else
    assign advance = 1'b1;
`endif

    // Plain 32-bit add: the top of the address space silently wraps to zero.
    assign pc_next = pc_reg + PC_INCR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (advance) begin
            pc_reg <= pc_next;
        end
    end

    assign pc_out = pc_reg;

    // Byte offset and bits above the index are dropped, so memory aliases.
    assign rd_idx = pc_reg[IDX_W+1:2];
    assign wr_idx = mem_waddr[IDX_W+1:2];
    assign unused_waddr_bits = ^{mem_waddr[XLEN-1:IDX_W+2], mem_waddr[1:0]};

    fetch_imem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_imem (
        .clk     (clk),
        .wr_en   (mem_wr),
        .wr_idx  (wr_idx),
        .wr_data (mem_wdata),
        .rd_idx  (rd_idx),
        .rd_data (instruction)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset vector, sequencing, preload,
// wrap-around aliasing, mid-run reset, write visibility and (FETCH_STALL_EN) stall.
module tb_fetch_unit;

    logic        clk = 1'b0;
    int          n_cmp = 0;
    int          n_mis = 0;

    // Instance A: default reset vector
    logic        reset_a;
    logic        stall_a;
    logic        mem_wr_a;
    logic [31:0] mem_waddr_a;
    logic [31:0] mem_wdata_a;
    logic [31:0] pc_out_a;
    logic [31:0] pc_next_a;
    logic [31:0] instr_a;

    // Instance B: reset vector near the top of the address space
    logic        reset_b;
    logic        stall_b;
    logic        mem_wr_b;
    logic [31:0] mem_waddr_b;
    logic [31:0] mem_wdata_b;
    logic [31:0] pc_out_b;
    logic [31:0] pc_next_b;
    logic [31:0] instr_b;

    always #5 clk = ~clk;

    fetch_unit #(
        .MEM_WORDS (16),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset_a),
`ifdef FETCH_STALL_EN
        .stall       (stall_a),
`endif
        .mem_wr      (mem_wr_a),
        .mem_waddr   (mem_waddr_a),
        .mem_wdata   (mem_wdata_a),
        .pc_out      (pc_out_a),
        .pc_next     (pc_next_a),
        .instruction (instr_a)
    );

    fetch_unit #(
        .MEM_WORDS (16),
        .RESET_PC  (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk         (clk),
        .reset       (reset_b),
`ifdef FETCH_STALL_EN
        .stall       (stall_b),
`endif
        .mem_wr      (mem_wr_b),
        .mem_waddr   (mem_waddr_b),
        .mem_wdata   (mem_wdata_b),
        .pc_out      (pc_out_b),
        .pc_next     (pc_next_b),
        .instruction (instr_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic check_a(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check({tag, " pc"}, pc_out_a, exp_pc);
        check({tag, " pc_next"}, pc_next_a, exp_pc + 32'd4);
        check({tag, " instr"}, instr_a, exp_instr);
    endtask

    task automatic check_b(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_next,
                           input logic [31:0] exp_instr);
        check({tag, " pc"}, pc_out_b, exp_pc);
        check({tag, " pc_next"}, pc_next_b, exp_next);
        check({tag, " instr"}, instr_b, exp_instr);
    endtask

    task automatic write_a(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_wr_a    = 1'b1;
        mem_waddr_a = addr;
        mem_wdata_a = data;
        @(negedge clk);
        mem_wr_a    = 1'b0;
    endtask

    task automatic write_b(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_wr_b    = 1'b1;
        mem_waddr_b = addr;
        mem_wdata_b = data;
        @(negedge clk);
        mem_wr_b    = 1'b0;
    endtask

    logic [31:0] seq_instr [4];

    initial begin
        seq_instr[0] = 32'h0000_00A0;
        seq_instr[1] = 32'h0000_00A1;
        seq_instr[2] = 32'h0000_00A2;
        seq_instr[3] = 32'h0000_00A3;

        reset_a = 1'b1; stall_a = 1'b0; mem_wr_a = 1'b0; mem_waddr_a = '0; mem_wdata_a = '0;
        reset_b = 1'b1; stall_b = 1'b0; mem_wr_b = 1'b0; mem_waddr_b = '0; mem_wdata_b = '0;

        // Preload during reset; byte offset and upper address bits must be ignored
        write_a(32'h0000_0000, 32'h0000_00A0);
        write_a(32'h0000_0005, 32'h0000_00A1);
        write_a(32'h0000_000A, 32'h0000_00A2);
        write_a(32'h1000_000C, 32'h0000_00A3);

        @(negedge clk);
        check_a("reset hold", 32'h0, 32'h0000_00A0);

        reset_a = 1'b0;
        #1;
        check_a("released", 32'h0, 32'h0000_00A0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check_a($sformatf("edge%0d", i), 32'(i * 4), seq_instr[i]);
        end

        @(negedge clk);
        check_a("unwritten word", 32'h10, 32'h0);

        // Asynchronous reset mid-cycle at pc=0x10
        #2;
        reset_a = 1'b1;
        #1;
        check("async reset pc", pc_out_a, 32'h0);
        check("async reset instr", instr_a, 32'h0000_00A0);
        @(negedge clk);
        check("reset held pc", pc_out_a, 32'h0);
        reset_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_a($sformatf("rerun%0d", i), 32'(i * 4), seq_instr[i]);
        end

        // Write the word under the PC while reset pins it at 0
        @(negedge clk);
        reset_a = 1'b1;
        #1;
        mem_wr_a    = 1'b1;
        mem_waddr_a = 32'h0;
        mem_wdata_a = 32'hDEAD_BEEF;
        #1;
        check("pre-write instr", instr_a, 32'h0000_00A0);
        @(posedge clk);
        #1;
        check("post-write instr", instr_a, 32'hDEAD_BEEF);
        mem_wr_a = 1'b0;
        @(negedge clk);
        check("post-write pc", pc_out_a, 32'h0);

`ifdef FETCH_STALL_EN
        reset_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_a("pre-stall", 32'h8, 32'h0000_00A2);
        stall_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_a($sformatf("stall%0d", i), 32'h8, 32'h0000_00A2);
        end
        stall_a = 1'b0;
        @(negedge clk);
        check_a("post-stall", 32'hC, 32'h0000_00A3);
        // Reset must win over stall
        stall_a = 1'b1;
        reset_a = 1'b1;
        #1;
        check("reset over stall", pc_out_a, 32'h0);
        stall_a = 1'b0;
`endif

        // Wrap-around instance: words 14, 15 and 0 of a 16-word memory
        write_b(32'h0000_0038, 32'h0000_00BE);
        write_b(32'h4000_003C, 32'h0000_00BF);
        write_b(32'h0000_0000, 32'h0000_00B0);
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        check_b("wrap0", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_00BE);
        @(negedge clk);
        check_b("wrap1", 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_00BF);
        @(negedge clk);
        check_b("wrap2", 32'h0000_0000, 32'h0000_0004, 32'h0000_00B0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning instruction memory depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (word aligned).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_wr  input  1  instruction memory write enable.
REQ-006 SHALL have port mem_waddr  input  32  byte address of the word to write.
REQ-007 SHALL have port mem_wdata  input  32  word to write.
REQ-008 SHALL have port pc_out  output  32  current PC (byte address).
REQ-009 SHALL have port pc_next  output  32  combinational pc_out + 4.
REQ-010 SHALL have port instruction  output  32  memory word addressed by pc_out.

Function
REQ-011 SHALL load pc_out <= pc_next on every rising clk edge while reset is low.
REQ-012 SHALL compute pc_next = pc_out + 32'd4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-013 SHALL drive instruction combinationally (zero-cycle latency) as mem[pc_out[log2(MEM_WORDS)+1:2]].
REQ-014 SHALL ignore pc_out[1:0] and all bits above the index field, so memory aliases modulo MEM_WORDS words.
REQ-015 SHALL write mem_wdata into mem[mem_waddr[log2(MEM_WORDS)+1:2]] on a rising clk edge when mem_wr=1; byte offset bits ignored.
REQ-016 SHALL, when writing the word being read, show the old word before the edge and the new word after it, with no bypass.
REQ-017 SHALL honour writes whether or not reset is asserted.
REQ-018 SHALL leave never-written words at 32'h0000_0000 at time zero in simulation; contents are undefined for synthesis.

Reset
REQ-019 SHALL force pc_out to RESET_PC immediately on reset assertion, independent of clk.
REQ-020 SHALL hold pc_out at RESET_PC while reset is high, and advance it on the first rising edge after deassertion.
REQ-021 SHALL NOT clear memory contents on reset; reset mid-run only restarts the PC.

Configuration
REQ-022 SHALL, when FETCH_STALL_EN is defined, add input port stall (1 bit, after reset); pc_out holds its value on any edge where stall=1, and instruction stays stable.
REQ-023 SHALL, when FETCH_STALL_EN is undefined, have no stall port, with the PC advancing every non-reset cycle.
REQ-024 SHALL give reset priority over stall.

Structure
REQ-025 SHALL place XLEN=32, PC_INCR=4 and the default RESET_PC constant in shared package fetch_pkg.
REQ-026 SHALL implement the memory array and write port in sub-module fetch_imem, with the PC register and incrementer in fetch_unit.

Verification
REQ-027 SHALL check: reset=1 then release -> pc_out=0 during reset; after edges 1, 2 and 3, pc_out=4, 8 and 32'hC; pc_next is always pc_out+4.
REQ-028 SHALL check: preload mem[0..3]=32'hA0..A3 via mem_wr during reset -> after release, instruction = A0, A1, A2, A3 on consecutive cycles.
REQ-029 SHALL check: RESET_PC=32'hFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; instruction aliases mem[MEM_WORDS-2], mem[MEM_WORDS-1], mem[0].
REQ-030 SHALL check: assert reset mid-cycle at pc_out=32'h10 -> pc_out=RESET_PC before the next edge, and memory contents are unchanged.
REQ-031 SHALL check: write 32'hDEAD_BEEF at the address equal to pc_out -> instruction changes only after the write edge.
REQ-032 SHALL check, with FETCH_STALL_EN: stall=1 for 2 cycles at pc_out=8 -> pc_out stays 8, then advances to 32'hC.
